pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the pc_reg → if_id → id → id_ex → ex datapath. It resolves three kinds of event: taken jumps/branches (redirect and flush), load-use hazards against the decoder's register reads (one-cycle stall plus bubble), and multi-cycle execute operations (hold the whole front end until the unit completes or times out). It owns the hold/flush controls of pc_reg, if_id and id_ex, and keeps a saturating stall-cycle counter.

---
 rtl/pipe_ctrl_if.sv | 40 ++++
 rtl/pipe_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline datapath and pipe_ctrl.
// slave is the controller side; master is the datapath side.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1_addr_i;
  logic [4:0]       id_rs2_addr_i;
  logic             ex_load_i;
  logic             ex_reg_wen_i;
  logic [4:0]       ex_rd_addr_i;
  logic             ex_jump_en_i;
  logic [31:0]      ex_jump_addr_i;
  logic             mc_req_i;
  logic             mc_done_i;
  logic             hold_pc_o;
  logic             hold_if_id_o;
  logic             hold_id_ex_o;
  logic             flush_if_id_o;
  logic             bubble_id_ex_o;
  logic             jump_en_o;
  logic [31:0]      jump_addr_o;
  logic             mc_start_o;
  logic             mc_abort_o;
  logic             mc_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport slave (
    input  id_rs1_addr_i, id_rs2_addr_i, ex_load_i, ex_reg_wen_i, ex_rd_addr_i,
           ex_jump_en_i, ex_jump_addr_i, mc_req_i, mc_done_i,
    output hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, bubble_id_ex_o,
           jump_en_o, jump_addr_o, mc_start_o, mc_abort_o, mc_timeout_o, stall_cnt_o
  );

  modport master (
    output id_rs1_addr_i, id_rs2_addr_i, ex_load_i, ex_reg_wen_i, ex_rd_addr_i,
           ex_jump_en_i, ex_jump_addr_i, mc_req_i, mc_done_i,
    input  hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, bubble_id_ex_o,
           jump_en_o, jump_addr_o, mc_start_o, mc_abort_o, mc_timeout_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: jump redirect/flush, load-use stall with bubble,
// and front-end hold around multi-cycle execute ops with timeout abort.
module pipe_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);
  localparam int WAIT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);

  typedef enum logic {RUN, MC_WAIT} state_t;

  state_t           r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic             r_mc_timeout;
  logic [CNT_W-1:0] r_stall_cnt;

  state_t           w_state_next;
  logic [WAIT_W-1:0] w_wait_cnt_next;
  logic             w_set_timeout;
  logic             w_luh;
  logic             w_hold_pc;
  logic             w_hold_if_id;
  logic             w_hold_id_ex;
  logic             w_flush_if_id;
  logic             w_bubble_id_ex;
  logic             w_jump_en;
  logic             w_mc_start;
  logic             w_mc_abort;

  assign w_luh = bus.ex_load_i & bus.ex_reg_wen_i & (bus.ex_rd_addr_i != 5'd0) &
                 ((bus.ex_rd_addr_i == bus.id_rs1_addr_i) |
                  (bus.ex_rd_addr_i == bus.id_rs2_addr_i));

  // Controls are forced quiet while rst is high so a request left on the bus
  // cannot leak a start pulse out of a reset.
  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_set_timeout   = 1'b0;
    w_hold_pc       = 1'b0;
    w_hold_if_id    = 1'b0;
    w_hold_id_ex    = 1'b0;
    w_flush_if_id   = 1'b0;
    w_bubble_id_ex  = 1'b0;
    w_jump_en       = 1'b0;
    w_mc_start      = 1'b0;
    w_mc_abort      = 1'b0;
    if (!rst) begin
      case (r_state)
        RUN: begin
          if (bus.ex_jump_en_i) begin
            w_jump_en      = 1'b1;
            w_flush_if_id  = 1'b1;
            w_bubble_id_ex = 1'b1;
          end else if (bus.mc_req_i) begin
            w_mc_start      = 1'b1;
            w_hold_pc       = 1'b1;
            w_hold_if_id    = 1'b1;
            w_hold_id_ex    = 1'b1;
            w_state_next    = MC_WAIT;
            w_wait_cnt_next = '0;
          end else if (w_luh) begin
            w_hold_pc      = 1'b1;
            w_hold_if_id   = 1'b1;
            w_bubble_id_ex = 1'b1;
          end
        end
        MC_WAIT: begin
          // Done takes precedence over a coincident timeout.
          if (bus.mc_done_i) begin
            w_state_next = RUN;
          end else if (r_wait_cnt == WAIT_LAST) begin
            w_mc_abort    = 1'b1;
            w_set_timeout = 1'b1;
            w_state_next  = RUN;
          end else begin
            w_hold_pc       = 1'b1;
            w_hold_if_id    = 1'b1;
            w_hold_id_ex    = 1'b1;
            w_wait_cnt_next = r_wait_cnt + WAIT_W'(1);
          end
        end
        default: w_state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RUN;
      r_wait_cnt   <= '0;
      r_mc_timeout <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_set_timeout) begin
        r_mc_timeout <= 1'b1;
      end
      if (w_hold_pc && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.hold_pc_o      = w_hold_pc;
  assign bus.hold_if_id_o   = w_hold_if_id;
  assign bus.hold_id_ex_o   = w_hold_id_ex;
  assign bus.flush_if_id_o  = w_flush_if_id;
  assign bus.bubble_id_ex_o = w_bubble_id_ex;
  assign bus.jump_en_o      = w_jump_en;
  assign bus.jump_addr_o    = w_jump_en ? bus.ex_jump_addr_i : 32'd0;
  assign bus.mc_start_o     = w_mc_start;
  assign bus.mc_abort_o     = w_mc_abort;
  assign bus.mc_timeout_o   = r_mc_timeout;
  assign bus.stall_cnt_o    = r_stall_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a default instance (64/32) and a small one (timeout 4,
// 2-bit counter) share one stimulus; expectations flow through a scoreboard queue.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        ld = 1'b0, wen = 1'b0, jmp = 1'b0, mreq = 1'b0, mdone = 1'b0;
  logic [31:0] jaddr = '0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(32)) ifa ();
  pipe_ctrl_if #(.CNT_W(2))  ifb ();

  assign ifa.id_rs1_addr_i = rs1;   assign ifb.id_rs1_addr_i = rs1;
  assign ifa.id_rs2_addr_i = rs2;   assign ifb.id_rs2_addr_i = rs2;
  assign ifa.ex_load_i = ld;        assign ifb.ex_load_i = ld;
  assign ifa.ex_reg_wen_i = wen;    assign ifb.ex_reg_wen_i = wen;
  assign ifa.ex_rd_addr_i = rd;     assign ifb.ex_rd_addr_i = rd;
  assign ifa.ex_jump_en_i = jmp;    assign ifb.ex_jump_en_i = jmp;
  assign ifa.ex_jump_addr_i = jaddr; assign ifb.ex_jump_addr_i = jaddr;
  assign ifa.mc_req_i = mreq;       assign ifb.mc_req_i = mreq;
  assign ifa.mc_done_i = mdone;     assign ifb.mc_done_i = mdone;

  pipe_ctrl #(.MC_TIMEOUT(64), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  pipe_ctrl #(.MC_TIMEOUT(4),  .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  // ctl bits: hold_pc, hold_if_id, hold_id_ex, flush, bubble, jump_en, mc_start, mc_abort
  wire [7:0] ctl_a = {ifa.hold_pc_o, ifa.hold_if_id_o, ifa.hold_id_ex_o, ifa.flush_if_id_o,
                      ifa.bubble_id_ex_o, ifa.jump_en_o, ifa.mc_start_o, ifa.mc_abort_o};
  wire [7:0] ctl_b = {ifb.hold_pc_o, ifb.hold_if_id_o, ifb.hold_id_ex_o, ifb.flush_if_id_o,
                      ifb.bubble_id_ex_o, ifb.jump_en_o, ifb.mc_start_o, ifb.mc_abort_o};

  localparam logic [7:0] C_IDLE  = 8'b0000_0000;
  localparam logic [7:0] C_JUMP  = 8'b0001_1100;
  localparam logic [7:0] C_MCREQ = 8'b1110_0010;
  localparam logic [7:0] C_LUH   = 8'b1100_1000;
  localparam logic [7:0] C_HOLD  = 8'b1110_0000;
  localparam logic [7:0] C_ABORT = 8'b0000_0001;

  typedef struct {
    logic [7:0]  ctl;
    logic [31:0] addr;
    logic [31:0] cnt;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1 = '0; rs2 = '0; rd = '0; ld = 1'b0; wen = 1'b0;
    jmp = 1'b0; jaddr = '0; mreq = 1'b0; mdone = 1'b0;
  endtask

  task automatic do_reset();
    next_cycle();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    idle_inputs();
    next_cycle();
    exp_q.push_back('{C_IDLE, 32'd0, 32'd0, 1'b0});
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if ({ctl_a, ctl_b, ifa.jump_addr_o, ifb.jump_addr_o, ifa.stall_cnt_o, ifb.stall_cnt_o,
         ifa.mc_timeout_o, ifb.mc_timeout_o} !==
        {e.ctl, e.ctl, e.addr, e.addr, e.cnt, e.cnt[1:0], e.tmo, e.tmo}) begin
      n_err++;
      $display("FAIL reset_hold: ctl_a=%b ctl_b=%b cnt_a=%0d tmo_a=%b, want ctl=%b cnt=0 tmo=0",
               ctl_a, ctl_b, ifa.stall_cnt_o, ifa.mc_timeout_o, e.ctl);
    end else $display("reset_hold: ctl_a=%b ctl_b=%b", ctl_a, ctl_b);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      exp_q.push_back('{C_IDLE, 32'd0, 32'd0, 1'b0});
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({ctl_a, ifa.jump_addr_o, ifa.stall_cnt_o, ifa.mc_timeout_o} !==
          {e.ctl, e.addr, e.cnt, e.tmo}) begin
        n_err++;
        $display("FAIL reset_idle c%0d: ctl=%b cnt=%0d tmo=%b, want ctl=%b cnt=%0d tmo=%b",
                 c, ctl_a, ifa.stall_cnt_o, ifa.mc_timeout_o, e.ctl, e.cnt, e.tmo);
      end else $display("reset_idle c%0d: ctl=%b cnt=%0d", c, ctl_a, ifa.stall_cnt_o);
    end
  endtask

  task automatic test_jump();
    exp_t e;
    logic        jmp_t  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic        req_t  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ja_t   [4] = '{32'h100, 32'h100, 32'h100, 32'hDEAD_BEE0};
    logic [7:0]  ctl_t  [4] = '{C_JUMP, C_JUMP, C_IDLE, C_JUMP};
    logic [31:0] addr_t [4] = '{32'h100, 32'h100, 32'h0, 32'hDEAD_BEE0};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      jmp = jmp_t[c]; mreq = req_t[c]; jaddr = ja_t[c];
      exp_q.push_back('{ctl_t[c], addr_t[c], 32'd0, 1'b0});
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({ctl_a, ifa.jump_addr_o, ifa.stall_cnt_o} !== {e.ctl, e.addr, e.cnt}) begin
        n_err++;
        $display("FAIL jump c%0d: ctl=%b addr=%h cnt=%0d, want ctl=%b addr=%h cnt=%0d",
                 c, ctl_a, ifa.jump_addr_o, ifa.stall_cnt_o, e.ctl, e.addr, e.cnt);
      end else $display("jump c%0d: ctl=%b addr=%h", c, ctl_a, ifa.jump_addr_o);
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    logic       ld_t  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       wen_t [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [4:0] rd_t  [6] = '{5'd5, 5'd5, 5'd0, 5'd7, 5'd7, 5'd0};
    logic [4:0] rs1_t [6] = '{5'd3, 5'd3, 5'd0, 5'd7, 5'd7, 5'd0};
    logic [4:0] rs2_t [6] = '{5'd5, 5'd5, 5'd9, 5'd1, 5'd1, 5'd0};
    logic [7:0] ctl_t [6] = '{C_LUH, C_IDLE, C_IDLE, C_LUH, C_IDLE, C_IDLE};
    int         cnt_t [6] = '{0, 1, 1, 1, 2, 2};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      ld = ld_t[c]; wen = wen_t[c]; rd = rd_t[c]; rs1 = rs1_t[c]; rs2 = rs2_t[c];
      exp_q.push_back('{ctl_t[c], 32'd0, 32'(cnt_t[c]), 1'b0});
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({ctl_a, ifa.stall_cnt_o} !== {e.ctl, e.cnt}) begin
        n_err++;
        $display("FAIL load_use c%0d: ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                 c, ctl_a, ifa.stall_cnt_o, e.ctl, e.cnt);
      end else $display("load_use c%0d: ctl=%b cnt=%0d", c, ctl_a, ifa.stall_cnt_o);
    end
  endtask

  task automatic test_multicycle();
    exp_t e;
    logic       req_t  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       done_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       noise_t[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] ctl_t  [5] = '{C_MCREQ, C_HOLD, C_HOLD, C_IDLE, C_IDLE};
    int         cnt_t  [5] = '{0, 1, 2, 3, 3};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      mreq = req_t[c]; mdone = done_t[c];
      // a jump and a load-use hazard presented mid-wait must be ignored
      jmp = noise_t[c]; jaddr = noise_t[c] ? 32'h40 : 32'h0;
      ld = noise_t[c]; wen = noise_t[c]; rd = 5'd5; rs1 = 5'd5;
      exp_q.push_back('{ctl_t[c], 32'd0, 32'(cnt_t[c]), 1'b0});
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({ctl_a, ifa.jump_addr_o, ifa.stall_cnt_o, ifa.mc_timeout_o} !==
          {e.ctl, e.addr, e.cnt, e.tmo}) begin
        n_err++;
        $display("FAIL multicycle c%0d: ctl=%b addr=%h cnt=%0d tmo=%b, want ctl=%b addr=%h cnt=%0d tmo=%b",
                 c, ctl_a, ifa.jump_addr_o, ifa.stall_cnt_o, ifa.mc_timeout_o,
                 e.ctl, e.addr, e.cnt, e.tmo);
      end else $display("multicycle c%0d: ctl=%b cnt=%0d", c, ctl_a, ifa.stall_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic       req_t  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       done_t [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] ctl_t  [6] = '{C_MCREQ, C_IDLE, C_MCREQ, C_HOLD, C_IDLE, C_IDLE};
    int         cnt_t  [6] = '{0, 1, 1, 2, 3, 3};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      mreq = req_t[c]; mdone = done_t[c];
      exp_q.push_back('{ctl_t[c], 32'd0, 32'(cnt_t[c]), 1'b0});
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({ctl_a, ifa.stall_cnt_o} !== {e.ctl, e.cnt}) begin
        n_err++;
        $display("FAIL back_to_back c%0d: ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                 c, ctl_a, ifa.stall_cnt_o, e.ctl, e.cnt);
      end else $display("back_to_back c%0d: ctl=%b cnt=%0d", c, ctl_a, ifa.stall_cnt_o);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    logic       req_t [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] ctl_t [7] = '{C_MCREQ, C_HOLD, C_HOLD, C_HOLD, C_ABORT, C_IDLE, C_IDLE};
    int         cnt_t [7] = '{0, 1, 2, 3, 3, 3, 3};
    logic       tmo_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      mreq = req_t[c];
      exp_q.push_back('{ctl_t[c], 32'd0, 32'(cnt_t[c]), tmo_t[c]});
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({ctl_b, ifb.stall_cnt_o, ifb.mc_timeout_o} !== {e.ctl, e.cnt[1:0], e.tmo}) begin
        n_err++;
        $display("FAIL timeout c%0d: ctl=%b cnt=%0d tmo=%b, want ctl=%b cnt=%0d tmo=%b",
                 c, ctl_b, ifb.stall_cnt_o, ifb.mc_timeout_o, e.ctl, e.cnt, e.tmo);
      end else $display("timeout c%0d: ctl=%b tmo=%b", c, ctl_b, ifb.mc_timeout_o);
    end
  endtask

  task automatic test_done_at_timeout();
    exp_t e;
    logic       req_t  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       done_t [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] ctl_t  [6] = '{C_MCREQ, C_HOLD, C_HOLD, C_HOLD, C_IDLE, C_IDLE};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      mreq = req_t[c]; mdone = done_t[c];
      exp_q.push_back('{ctl_t[c], 32'd0, 32'd0, 1'b0});
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({ctl_b, ifb.mc_timeout_o} !== {e.ctl, e.tmo}) begin
        n_err++;
        $display("FAIL done_at_timeout c%0d: ctl=%b tmo=%b, want ctl=%b tmo=%b",
                 c, ctl_b, ifb.mc_timeout_o, e.ctl, e.tmo);
      end else $display("done_at_timeout c%0d: ctl=%b tmo=%b", c, ctl_b, ifb.mc_timeout_o);
    end
  endtask

  task automatic test_reset_in_wait();
    exp_t e;
    logic       req_t [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       rst_t [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] ctl_t [5] = '{C_MCREQ, C_HOLD, C_IDLE, C_IDLE, C_IDLE};
    int         cnt_t [5] = '{0, 1, 0, 0, 0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      mreq = req_t[c]; rst = rst_t[c];
      exp_q.push_back('{ctl_t[c], 32'd0, 32'(cnt_t[c]), 1'b0});
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({ctl_a, ifa.stall_cnt_o, ifa.mc_timeout_o} !== {e.ctl, e.cnt, e.tmo}) begin
        n_err++;
        $display("FAIL reset_in_wait c%0d: ctl=%b cnt=%0d tmo=%b, want ctl=%b cnt=%0d tmo=%b",
                 c, ctl_a, ifa.stall_cnt_o, ifa.mc_timeout_o, e.ctl, e.cnt, e.tmo);
      end else $display("reset_in_wait c%0d: ctl=%b cnt=%0d", c, ctl_a, ifa.stall_cnt_o);
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    logic ld_t  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int   cnt_t [6] = '{0, 1, 2, 3, 3, 3};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      ld = ld_t[c]; wen = ld_t[c]; rd = 5'd5; rs1 = 5'd5;
      exp_q.push_back('{ld_t[c] ? C_LUH : C_IDLE, 32'd0, 32'(cnt_t[c]), 1'b0});
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({ctl_b, ifb.stall_cnt_o} !== {e.ctl, e.cnt[1:0]}) begin
        n_err++;
        $display("FAIL saturate c%0d: ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                 c, ctl_b, ifb.stall_cnt_o, e.ctl, e.cnt);
      end else $display("saturate c%0d: ctl=%b cnt=%0d", c, ctl_b, ifb.stall_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_load_use();
    test_multicycle();
    test_back_to_back();
    test_timeout();
    test_done_at_timeout();
    test_reset_in_wait();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
